// File: rtl/aes_stream_engine.sv
// Stream engine: pass, a^b or a^key over a fixed-length job.
// One-deep registered output slot, one beat per cycle at full rate.
module aes_stream_engine #(
  parameter int DW    = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [DW-1:0]    a_data_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [DW-1:0]    b_data_i,
  output logic             d_valid_o,
  input  logic             d_ready_i,
  output logic [DW-1:0]    d_data_o,
  output logic [DW/8-1:0]  d_strb_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    key_q, key_d;
  logic [DW-1:0]    d_data_q, d_data_d;
  logic             d_valid_q, d_valid_d;

  logic             slot_free;
  logic             first_beat;
  logic             fire;
  logic             b_rdy;
  logic [DW-1:0]    res;

  assign slot_free  = !d_valid_q || d_ready_i;
  assign first_beat = (in_cnt_q == '0);

  always_comb begin
    fire  = 1'b0;
    b_rdy = 1'b0;
    res   = a_data_i;
    if (state_q == RUN) begin
      unique case (1'b1)
        (mode_q == 2'd1),
        (mode_q == 2'd2 && first_beat): begin
          fire  = a_valid_i && b_valid_i && slot_free;
          b_rdy = fire;
          res   = a_data_i ^ b_data_i;
        end
        (mode_q == 2'd2 && !first_beat): begin
          fire = a_valid_i && slot_free;
          res  = a_data_i ^ key_q;
        end
        default: begin
          fire = a_valid_i && slot_free;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    d_data_d  = d_data_q;
    d_valid_d = d_valid_q;
    if (d_valid_q && d_ready_i) begin
      cnt_d     = cnt_q + 1'b1;
      d_valid_d = 1'b0;
    end
    if (fire) begin
      d_valid_d = 1'b1;
      d_data_d  = res;
      in_cnt_d  = in_cnt_q + 1'b1;
      if (mode_q == 2'd2 && first_beat) begin
        key_d = b_data_i;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d   = mode_i;
          len_d    = len_i;
          in_cnt_d = '0;
          cnt_d    = '0;
          state_d  = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_cnt_d == len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == len_q) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Soft clear aborts exactly like reset, dropping any pending beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      d_data_q  <= '0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      d_data_q  <= d_data_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign a_ready_o = fire;
  assign b_ready_o = b_rdy;
  assign d_valid_o = d_valid_q;
  assign d_data_o  = d_data_q;
  assign d_strb_o  = {(DW/8){d_valid_q}};
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_aes_stream_engine.sv
// Directed bench for aes_stream_engine.
// Each task drives one scenario and checks against hand values.
module tb_aes_stream_engine;

  localparam int DW    = 128;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] len;
  logic             a_valid;
  logic             a_ready;
  logic [DW-1:0]    a_data;
  logic             b_valid;
  logic             b_ready;
  logic [DW-1:0]    b_data;
  logic             d_valid;
  logic             d_ready;
  logic [DW-1:0]    d_data;
  logic [DW/8-1:0]  d_strb;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int a_hs = 0;
  int b_hs = 0;
  logic [DW-1:0] beats[$];

  aes_stream_engine #(
    .DW(DW),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .clear_i(clear),
    .start_i(start),
    .mode_i(mode),
    .len_i(len),
    .a_valid_i(a_valid),
    .a_ready_o(a_ready),
    .a_data_i(a_data),
    .b_valid_i(b_valid),
    .b_ready_o(b_ready),
    .b_data_i(b_data),
    .d_valid_o(d_valid),
    .d_ready_i(d_ready),
    .d_data_o(d_data),
    .d_strb_o(d_strb),
    .busy_o(busy),
    .done_o(done),
    .cnt_o(cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (a_valid && a_ready) a_hs++;
    if (b_valid && b_ready) b_hs++;
    if (d_valid && d_ready) beats.push_back(d_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] m, input int l);
    mode  = m;
    len   = CNT_W'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0;
    start = 1'b1; mode = 2'd0; len = 16'd3;
    a_valid = 1'b1; a_data = '0;
    b_valid = 1'b1; b_data = '0;
    d_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({d_valid, done, busy, a_ready, b_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b exp 00000",
               {d_valid, done, busy, a_ready, b_ready});
    end
    n_cmp++;
    if (d_data !== '0 || cnt !== '0) begin
      n_bad++;
      $display("FAIL rst_data got %h/%0d exp 0/0", d_data, cnt);
    end
    rst_n = 1'b1; start = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    int d0;
    d0 = done_cnt;
    go(2'd0, 4);
    a_valid = 1'b1; d_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_data = DW'(i);
      #1;
      n_cmp++;
      if (a_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL pass_rdy%0d got %b exp 1", i, a_ready);
      end
      tick();
      n_cmp++;
      if (d_valid !== 1'b1 || d_data !== DW'(i)
          || d_strb !== '1) begin
        n_bad++;
        $display("FAIL pass_d%0d got %h exp %0d", i, d_data, i);
      end
    end
    a_valid = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL pass_done got %b/%0d exp 1/4", done, cnt);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL pass_idle got %b%b/%0d exp 00/4",
               done, busy, cnt);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL pass_pulses got %0d exp 1", done_cnt - d0);
    end
  endtask

  task automatic test_xor_delayed();
    int a0;
    int b0;
    a0 = a_hs; b0 = b_hs;
    go(2'd1, 2);
    a_valid = 1'b1; a_data = DW'(8'hF0);
    b_valid = 1'b0; b_data = DW'(8'hFF);
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL xor_wait%0d got %b%b exp 00",
                 i, a_ready, b_ready);
      end
      tick();
    end
    b_valid = 1'b1;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL xor_rdy got %b%b exp 11", a_ready, b_ready);
    end
    tick();
    n_cmp++;
    if (d_data !== DW'(8'h0F)) begin
      n_bad++;
      $display("FAIL xor_d0 got %h exp 0f", d_data);
    end
    a_data = DW'(8'h0F);
    tick();
    n_cmp++;
    if (d_data !== DW'(8'hF0)) begin
      n_bad++;
      $display("FAIL xor_d1 got %h exp f0", d_data);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || a_hs - a0 !== 2 || b_hs - b0 !== 2) begin
      n_bad++;
      $display("FAIL xor_end got %b/%0d/%0d exp 1/2/2",
               done, a_hs - a0, b_hs - b0);
    end
    tick();
  endtask

  task automatic test_key();
    int b0;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hAA; exp_d[1] = 8'hAB; exp_d[2] = 8'hA8;
    b0 = b_hs;
    go(2'd2, 3);
    d_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    b_data = DW'(8'hAA);
    for (int i = 0; i < 3; i++) begin
      a_data = DW'(i);
      if (i > 0) b_data = DW'(8'h55);
      #1;
      n_cmp++;
      if (b_ready !== (i == 0)) begin
        n_bad++;
        $display("FAIL key_brdy%0d got %b", i, b_ready);
      end
      tick();
      n_cmp++;
      if (d_data !== DW'(exp_d[i])) begin
        n_bad++;
        $display("FAIL key_d%0d got %h exp %h",
                 i, d_data, exp_d[i]);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || b_hs - b0 !== 1) begin
      n_bad++;
      $display("FAIL key_end got %b/%0d exp 1/1", done, b_hs - b0);
    end
    tick();
  endtask

  task automatic test_stall();
    int q0;
    q0 = beats.size();
    go(2'd0, 3);
    d_ready = 1'b1; a_valid = 1'b1;
    a_data = DW'(8'h11);
    tick();
    a_data = DW'(8'h22);
    tick();
    d_ready = 1'b0;
    a_data = DW'(8'h33);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (a_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_rdy%0d got %b exp 0", i, a_ready);
      end
      tick();
      n_cmp++;
      if (d_valid !== 1'b1 || d_data !== DW'(8'h22)) begin
        n_bad++;
        $display("FAIL stall_d%0d got %b/%h exp 1/22",
                 i, d_valid, d_data);
      end
    end
    d_ready = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL stall_done got %b/%0d exp 1/3", done, cnt);
    end
    n_cmp++;
    if (beats.size() - q0 !== 3) begin
      n_bad++;
      $display("FAIL stall_nbeats got %0d exp 3",
               beats.size() - q0);
    end else begin
      n_cmp++;
      if (beats[q0] !== DW'(8'h11) || beats[q0+1] !== DW'(8'h22)
          || beats[q0+2] !== DW'(8'h33)) begin
        n_bad++;
        $display("FAIL stall_seq got %h %h %h exp 11 22 33",
                 beats[q0], beats[q0+1], beats[q0+2]);
      end
    end
    tick();
  endtask

  task automatic test_zero_len();
    int a0;
    a0 = a_hs;
    a_valid = 1'b1; b_valid = 1'b1;
    d_ready = 1'b1;
    mode = 2'd1; len = '0; start = 1'b1;
    #1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || cnt !== '0 || a_ready || b_ready) begin
      n_bad++;
      $display("FAIL zlen_done got %b/%0d/%b%b exp 1/0/00",
               done, cnt, a_ready, b_ready);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || a_hs - a0 !== 0) begin
      n_bad++;
      $display("FAIL zlen_idle got %b%b/%0d exp 00/0",
               done, busy, a_hs - a0);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    go(2'd0, 5);
    a_valid = 1'b1; d_ready = 1'b1;
    a_data = DW'(1);
    tick();
    a_data = DW'(2);
    tick();
    rst_n = 1'b0; a_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (d_valid !== 1'b0 || busy !== 1'b0 || cnt !== '0) begin
      n_bad++;
      $display("FAIL abort_state got %b%b/%0d exp 00/0",
               d_valid, busy, cnt);
    end
    tick(); tick();
    n_cmp++;
    if (done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL abort_done got %0d exp 0", done_cnt - d0);
    end
    go(2'd0, 2);
    a_valid = 1'b1;
    a_data = DW'(7);
    tick();
    n_cmp++;
    if (d_data !== DW'(7)) begin
      n_bad++;
      $display("FAIL abort_new0 got %h exp 7", d_data);
    end
    a_data = DW'(8);
    tick();
    n_cmp++;
    if (d_data !== DW'(8)) begin
      n_bad++;
      $display("FAIL abort_new1 got %h exp 8", d_data);
    end
    a_valid = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL abort_end got %b/%0d exp 1/2", done, cnt);
    end
    tick();
  endtask

  task automatic test_clear();
    int d0;
    d0 = done_cnt;
    clear = 1'b1;
    go(2'd0, 3);
    clear = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_start got busy %b exp 0", busy);
    end
    go(2'd0, 3);
    a_valid = 1'b1; d_ready = 1'b0;
    a_data = DW'(9);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; a_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || d_valid !== 1'b0 || cnt !== '0) begin
      n_bad++;
      $display("FAIL clr_mid got %b%b/%0d exp 00/0",
               busy, d_valid, cnt);
    end
    tick(); tick();
    n_cmp++;
    if (done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL clr_done got %0d exp 0", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_xor_delayed();
    test_key();
    test_stall();
    test_zero_len();
    test_abort();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_stream_engine.md
AES_STREAM_ENGINE -- requirements
Module: aes_stream_engine

Interface
REQ-001 SHALL have parameter DW, default 128: stream data width in bits; a multiple of 8.
REQ-002 SHALL have parameter CNT_W, default 16: width of the beat-length and beat-count fields.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous soft clear, active-high.
REQ-006 SHALL have port start_i, input, 1 bit: job start pulse.
REQ-007 SHALL have port mode_i, input, 2 bits: 0 = pass, 1 = a XOR b, 2 = a XOR held key, 3 = reserved.
REQ-008 SHALL have port len_i, input, CNT_W bits: job length in beats.
REQ-009 SHALL have ports a_valid_i (input, 1), a_ready_o (output, 1) and a_data_i (input, DW): input stream a.
REQ-010 SHALL have ports b_valid_i (input, 1), b_ready_o (output, 1) and b_data_i (input, DW): input stream b, carrying data or key.
REQ-011 SHALL have ports d_valid_o (output, 1), d_ready_i (input, 1), d_data_o (output, DW) and d_strb_o (output, DW/8): output stream d.
REQ-012 SHALL have port busy_o, output, 1 bit: a job is active.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse at job end.
REQ-014 SHALL have port cnt_o, output, CNT_W bits: output beats accepted in the current job.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE: a_ready_o, b_ready_o and d_valid_o SHALL all be 0.
REQ-017 IDLE with start_i=1 and len_i!=0: SHALL latch mode_i and len_i, clear the input counter and cnt_o, and enter RUN.
REQ-018 IDLE with start_i=1 and len_i=0: SHALL enter DONE next cycle; no stream beat is consumed.
REQ-019 start_i outside IDLE SHALL be ignored; latched mode and length SHALL be stable for the whole job.
REQ-020 Output slot free SHALL mean (!d_valid_o | d_ready_i).
REQ-021 Mode 0 and mode 3: a beat SHALL fire when a_valid_i=1 and the slot is free; result = a_data_i; b_ready_o=0.
REQ-022 Mode 1: a beat SHALL fire only when a_valid_i=1, b_valid_i=1 and the slot is free; a_ready_o and b_ready_o SHALL assert together on that cycle; result = a_data_i XOR b_data_i.
REQ-023 Mode 2, first beat: SHALL require both a and b valid; SHALL load the key register from b_data_i; result = a XOR b.
REQ-024 Mode 2, later beats: SHALL consume a only, b_ready_o=0; result = a XOR key.
REQ-025 Ready outputs SHALL be 0 whenever the beat cannot fire; an input SHALL never be consumed without a matching output write.
REQ-026 Latency: a result SHALL appear on d_data_o with d_valid_o=1 on the cycle after its input handshake.
REQ-027 d_strb_o SHALL be all ones while d_valid_o=1.
REQ-028 d_valid_o SHALL remain 1 and d_data_o SHALL remain stable until d_ready_i=1.
REQ-029 A new beat firing in the same cycle as d_ready_i=1 SHALL replace the output beat; full throughput SHALL be 1 beat per cycle.
REQ-030 The input counter SHALL increment on each fired beat.
REQ-031 When the input counter equals the latched length, inputs SHALL stop (readies 0) and the block SHALL enter DRAIN.
REQ-032 cnt_o SHALL increment on each d handshake; it does not wrap because it is bounded by len_i <= 2^CNT_W-1.
REQ-033 DRAIN: SHALL enter DONE on the cycle after the last output handshake, i.e. when cnt_o = latched length.
REQ-034 DONE: done_o=1 for exactly one cycle, then IDLE; cnt_o SHALL hold its final value until the next start.
REQ-035 busy_o SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-036 clear_i=1 SHALL behave as reset on the same edge, taking priority over every other event, including start_i and handshakes.

Reset
REQ-037 On a rising clk_i edge with rst_ni=0: state = IDLE; counters = 0; key register = 0; d_valid_o = 0; d_data_o = 0; done_o = 0; busy_o = 0; cnt_o = 0.
REQ-038 Reset or clear asserted mid-job SHALL abort the job without a done_o pulse; a pending output beat SHALL be dropped.
REQ-039 Reset SHALL have no effect between clock edges; outputs SHALL change only on clock edges.

Verification
REQ-040 Mode 0, len=4, a = 1,2,3,4, d_ready_i held 1 -> d beats 1,2,3,4 on consecutive cycles; done_o pulses once; cnt_o=4.
REQ-041 Mode 1, len=2, a = 0xF0,0x0F, b = 0xFF,0xFF, b_valid_i delayed 3 cycles -> no a consumed before b valid; d = 0x0F, 0xF0.
REQ-042 Mode 2, len=3, b first beat = 0xAA, a = 0,1,2 -> d = 0xAA,0xAB,0xA8; exactly one b handshake.
REQ-043 Mode 0, len=3, d_ready_i low for 5 cycles on beat 2 -> d_data_o stable and a_ready_o=0 throughout the stall; no beat lost or duplicated.
REQ-044 start with len=0 -> done_o pulses, no ready asserted, cnt_o=0.
REQ-045 rst_ni=0 for one cycle after 2 of 5 beats -> IDLE, d_valid_o=0, no done_o; a new job then runs correctly.
